// File: rtl/qed_pkg.sv
// Shared types and constants for the QED duplicate scheduler.
package qed_pkg;

  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] QED_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ORIG = 1'b0,
    DUP  = 1'b1
  } qed_state_t;

endpackage

// File: rtl/qed_dup_fifo.sv
// In-order queue of transformed duplicates; the head is presented combinationally.
module qed_dup_fifo
  import qed_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [INSN_W-1:0] wdata,
  output logic [INSN_W-1:0] head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W+1){1'b0}};

  logic [INSN_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == ZERO_CNT);
  assign count = count_q;
  // An empty queue shows a NOP rather than stale storage.
  assign head  = empty ? QED_NOP : mem_q[rd_ptr_q];

  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    wr_ptr_d  = do_push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= ZERO_CNT;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/qed_dup_scheduler.sv
// ORIG/DUP sequencing controller for the QED instruction mux.
// Optional QED_AUTO_DRAIN_EN: a full queue forces DUP instead of holding fetch.
module qed_dup_scheduler
  import qed_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              ifu_valid,
  input  logic              stall,
  input  logic [INSN_W-1:0] qed_dup_instruction,
  input  logic              dup_req,
  output logic              exec_dup,
  output logic [INSN_W-1:0] qed_instruction,
  output logic              fetch_hold,
  output logic              qed_ready
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W+1){1'b0}};

  qed_state_t      state_q, state_d;
  logic            paired_q, paired_d;
  logic            qed_ready_q;
  logic            accept_s, push_s, pop_s, forced_s;
  logic            full_s, empty_s;
  logic [ADDR_W:0] count_s, count_next_s;

  qed_dup_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (qed_dup_instruction),
    .head  (qed_instruction),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef QED_AUTO_DRAIN_EN
  assign fetch_hold = 1'b0;
  assign forced_s   = (count_next_s == FULL_CNT);
`else
  assign fetch_hold = (state_q == ORIG) && (count_s == FULL_CNT);
  assign forced_s   = 1'b0;
`endif

  assign exec_dup  = ena & (state_q == DUP);
  assign qed_ready = qed_ready_q;

  always_comb begin
    accept_s = ena & ifu_valid & ~stall & ~fetch_hold;
    push_s   = accept_s & (state_q == ORIG);
    pop_s    = accept_s & (state_q == DUP);
    case ({push_s & ~full_s, pop_s & ~empty_s})
      2'b10:   count_next_s = count_s + 1'b1;
      2'b01:   count_next_s = count_s - 1'b1;
      default: count_next_s = count_s;
    endcase
    state_d  = state_q;
    paired_d = paired_q;
    case (state_q)
      ORIG: begin
        if (ena & ((dup_req & (count_next_s != ZERO_CNT)) | forced_s)) begin
          state_d = DUP;
        end else begin
          state_d = ORIG;
        end
      end
      DUP: begin
        // The first completed replay marks the stream as balanced for good.
        if (ena & (count_next_s == ZERO_CNT)) begin
          state_d  = ORIG;
          paired_d = 1'b1;
        end else begin
          state_d = DUP;
        end
      end
      default: state_d = ORIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ORIG;
      paired_q    <= 1'b0;
      qed_ready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paired_q <= paired_d;
      if (ena) begin
        qed_ready_q <= (state_q == ORIG) && (count_s == ZERO_CNT) && paired_q;
      end else begin
        qed_ready_q <= qed_ready_q;
      end
    end
  end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler with a queue-based reference model.
module tb_qed_dup_scheduler;

  logic        clk = 1'b0;
  logic        rst, ena, ifu_valid, stall, dup_req;
  logic [31:0] insn;
  logic        exec_dup, fetch_hold, qed_ready;
  logic [31:0] qed_instruction;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] q[$];
  bit m_dup = 1'b0, m_paired = 1'b0, m_ready = 1'b0;

  always #5 clk = ~clk;

  qed_dup_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .ifu_valid           (ifu_valid),
    .stall               (stall),
    .qed_dup_instruction (insn),
    .dup_req             (dup_req),
    .exec_dup            (exec_dup),
    .qed_instruction     (qed_instruction),
    .fetch_hold          (fetch_hold),
    .qed_ready           (qed_ready)
  );

  function automatic bit model_hold();
`ifdef QED_AUTO_DRAIN_EN
    return 1'b0;
`else
    return !m_dup && (q.size() == 16);
`endif
  endfunction

  function automatic bit model_forced();
`ifdef QED_AUTO_DRAIN_EN
    return q.size() == 16;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: ORIG queues duplicates, DUP replays them until none remain.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dup = 1'b0; m_paired = 1'b0; m_ready = 1'b0;
    end else if (ena) begin
      bit acc, was_ready;
      acc       = ifu_valid && !stall && !model_hold();
      was_ready = !m_dup && (q.size() == 0) && m_paired;
      if (!m_dup) begin
        if (acc) q.push_back(insn);
        if ((dup_req && q.size() != 0) || model_forced()) m_dup = 1'b1;
      end else begin
        if (acc) void'(q.pop_front());
        if (q.size() == 0) begin
          m_dup = 1'b0;
          m_paired = 1'b1;
        end
      end
      m_ready = was_ready;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, half a period after each edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_exec;
      exp_exec = ena && m_dup;
      chk("exec_dup", {31'd0, exec_dup}, {31'd0, exp_exec});
      chk("fetch_hold", {31'd0, fetch_hold}, {31'd0, model_hold()});
      chk("qed_ready", {31'd0, qed_ready}, {31'd0, m_ready});
      if (exp_exec && q.size() > 0) chk("head", qed_instruction, q[0]);
    end
  end

  task automatic step(input logic r, input logic e, input logic v, input logic s,
                      input logic d, input logic [31:0] ins);
    rst = r; ena = e; ifu_valid = v; stall = s; dup_req = d; insn = ins;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; ifu_valid = 1'b0; stall = 1'b0; dup_req = 1'b0; insn = 32'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_en = 1'b1;
    chk("rst_exec", {31'd0, exec_dup}, 32'd0);
    chk("rst_hold", {31'd0, fetch_hold}, 32'd0);
    chk("rst_ready", {31'd0, qed_ready}, 32'd0);

    // Basic ORIG -> DUP -> ORIG round trip
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA_0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA_0002);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA_0003);
    chk("t1_orig", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t1_dup", {31'd0, exec_dup}, 32'd1);
    chk("t1_head_A", qed_instruction, 32'hAAAA_0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t1_head_B", qed_instruction, 32'hAAAA_0002);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t1_head_C", qed_instruction, 32'hAAAA_0003);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t1_exec_off", {31'd0, exec_dup}, 32'd0);
    chk("t1_ready_lag", {31'd0, qed_ready}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_ready", {31'd0, qed_ready}, 32'd1);

    // Stall in DUP holds the head
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBBBB_0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002);
    chk("t2_dup", {31'd0, exec_dup}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_0000);
      chk("t2_stall_exec", {31'd0, exec_dup}, 32'd1);
      chk("t2_stall_head", qed_instruction, 32'hBBBB_0001);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t2_head_2", qed_instruction, 32'hBBBB_0002);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t2_done", {31'd0, exec_dup}, 32'd0);

    // dup_req with an empty queue stays in ORIG
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t4_stay_orig", {31'd0, exec_dup}, 32'd0);

    // Fill to capacity
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100 + i);
`ifdef QED_AUTO_DRAIN_EN
    chk("t3_forced", {31'd0, exec_dup}, 32'd1);
    chk("t3_head0", qed_instruction, 32'h0000_0100);
`else
    chk("t3_hold", {31'd0, fetch_hold}, 32'd1);
    chk("t3_no_dup", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0999);
    chk("t3_hold_17", {31'd0, fetch_hold}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t3_dup", {31'd0, exec_dup}, 32'd1);
    chk("t3_head0", qed_instruction, 32'h0000_0100);
`endif
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t3_last", qed_instruction, 32'h0000_010F);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
    chk("t3_drained", {31'd0, exec_dup}, 32'd0);
    chk("t3_hold_clr", {31'd0, fetch_hold}, 32'd0);

    // ena=0 freezes everything, in ORIG and in DUP
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCCCC_0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCCCC_0002);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC_00FF);
    chk("t6_off_exec", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t6_dup", {31'd0, exec_dup}, 32'd1);
    chk("t6_head", qed_instruction, 32'hCCCC_0001);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_dup_off", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t6_resume", {31'd0, exec_dup}, 32'd1);
    chk("t6_resume_head", qed_instruction, 32'hCCCC_0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_head2", qed_instruction, 32'hCCCC_0002);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset mid-DUP with five queued
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hEEEE_0000 + i);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t5_dup", {31'd0, exec_dup}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t5_rst_exec", {31'd0, exec_dup}, 32'd0);
    chk("t5_rst_ready", {31'd0, qed_ready}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t5_empty", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_0009);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t5_fresh_head", qed_instruction, 32'h5555_0009);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t5_fresh_done", {31'd0, exec_dup}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
